// File: rtl/vga_cursor_overlay.sv
// VGA timing generator with a frame-synchronous, clamped, blinking cursor overlay.
// Colour and syncs leave through the same two-stage pipeline so they stay aligned.
module vga_cursor_overlay #(
   parameter int H_ACTIVE     = 640,
   parameter int H_FP         = 16,
   parameter int H_SYNC       = 96,
   parameter int H_BP         = 48,
   parameter int V_ACTIVE     = 480,
   parameter int V_FP         = 10,
   parameter int V_SYNC       = 2,
   parameter int V_BP         = 33,
   parameter int CURSOR_R     = 3,
   parameter int COLOR_W      = 1,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   pix_en,
   input  logic [9:0]             x_coordinate,
   input  logic [9:0]             y_coordinate,
   input  logic                   coord_valid,
   input  logic [1:0]             mode,
   input  logic                   blink_en,
   input  logic [3*COLOR_W-1:0]   bg_color,
   input  logic [3*COLOR_W-1:0]   cursor_color,
   output logic                   vga_h_sync,
   output logic                   vga_v_sync,
   output logic [COLOR_W-1:0]     vga_r,
   output logic [COLOR_W-1:0]     vga_g,
   output logic [COLOR_W-1:0]     vga_b,
   output logic                   frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int BW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] X_MAX    = 10'(H_ACTIVE - 1);
   localparam logic [9:0] Y_MAX    = 10'(V_ACTIVE - 1);
   localparam logic [9:0] X_RST    = 10'(H_ACTIVE / 2);
   localparam logic [9:0] Y_RST    = 10'(V_ACTIVE / 2);
   localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic signed [10:0] R_S = 11'(CURSOR_R);
   localparam logic [BW-1:0] B_LAST  = BW'(BLINK_FRAMES - 1);

   logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [9:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
   logic [9:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          visible_q, visible_d;
   logic          commit;

   logic signed [10:0] dx, dy, adx, ady;
   logic               in_box, hit;

   logic                 s1_act_q, s1_hit_q, s1_hs_q, s1_vs_q;
   logic [3*COLOR_W-1:0] s1_bg_q, s1_fg_q;
   logic                 hs_q, vs_q;
   logic [3*COLOR_W-1:0] rgb_q, rgb_d;

   // Last pixel before vertical blank: the only point where the cursor may move.
   assign commit = pix_en && (h_cnt_q == H_LAST) && (v_cnt_q == Y_MAX);

   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (pix_en) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
         end else begin
            h_cnt_d = h_cnt_q + 10'd1;
         end
      end
   end

   always_comb begin
      pend_x_d = pend_x_q;
      pend_y_d = pend_y_q;
      cur_x_d  = cur_x_q;
      cur_y_d  = cur_y_q;
      if (coord_valid) begin
         pend_x_d = (x_coordinate > X_MAX) ? X_MAX : x_coordinate;
         pend_y_d = (y_coordinate > Y_MAX) ? Y_MAX : y_coordinate;
      end
      if (commit) begin
         cur_x_d = pend_x_q;
         cur_y_d = pend_y_q;
      end
   end

   always_comb begin
      blink_cnt_d = blink_cnt_q;
      visible_d   = visible_q;
      if (!blink_en) begin
         blink_cnt_d = '0;
         visible_d   = 1'b1;
      end else if (commit) begin
         if (blink_cnt_q == B_LAST) begin
            blink_cnt_d = '0;
            visible_d   = ~visible_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
         end
      end
   end

   // Signed offsets keep a cursor near the edge from wrapping to the far side.
   always_comb begin
      dx     = $signed({1'b0, h_cnt_q}) - $signed({1'b0, cur_x_q});
      dy     = $signed({1'b0, v_cnt_q}) - $signed({1'b0, cur_y_q});
      adx    = dx[10] ? -dx : dx;
      ady    = dy[10] ? -dy : dy;
      in_box = (adx <= R_S) && (ady <= R_S);
      case (mode)
         2'd1:    hit = in_box;
         2'd2:    hit = in_box && ((adx == R_S) || (ady == R_S));
         2'd3:    hit = (dx == 11'sd0) || (dy == 11'sd0);
         default: hit = 1'b0;
      endcase
   end

   always_comb begin
      rgb_d = '0;
      if (s1_act_q) rgb_d = s1_hit_q ? s1_fg_q : s1_bg_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         pend_x_q    <= X_RST;
         pend_y_q    <= Y_RST;
         cur_x_q     <= X_RST;
         cur_y_q     <= Y_RST;
         blink_cnt_q <= '0;
         visible_q   <= 1'b1;
      end else begin
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         pend_x_q    <= pend_x_d;
         pend_y_q    <= pend_y_d;
         cur_x_q     <= cur_x_d;
         cur_y_q     <= cur_y_d;
         blink_cnt_q <= blink_cnt_d;
         visible_q   <= visible_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_act_q <= 1'b0;
         s1_hit_q <= 1'b0;
         s1_hs_q  <= 1'b1;
         s1_vs_q  <= 1'b1;
         s1_bg_q  <= '0;
         s1_fg_q  <= '0;
         hs_q     <= 1'b1;
         vs_q     <= 1'b1;
         rgb_q    <= '0;
      end else if (pix_en) begin
         s1_act_q <= (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
         s1_hit_q <= hit && visible_q;
         s1_hs_q  <= ~((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
         s1_vs_q  <= ~((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
         s1_bg_q  <= bg_color;
         s1_fg_q  <= cursor_color;
         hs_q     <= s1_hs_q;
         vs_q     <= s1_vs_q;
         rgb_q    <= rgb_d;
      end
   end

   assign vga_h_sync  = hs_q;
   assign vga_v_sync  = vs_q;
   assign vga_r       = rgb_q[3*COLOR_W-1 -: COLOR_W];
   assign vga_g       = rgb_q[2*COLOR_W-1 -: COLOR_W];
   assign vga_b       = rgb_q[COLOR_W-1:0];
   assign frame_start = pix_en && !reset && (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: tb/tb_vga_cursor_overlay.sv
// Randomized scoreboard bench for vga_cursor_overlay on a shrunken raster,
// with expected pixels computed from screen geometry rather than pipeline state.
module tb_vga_cursor_overlay;

   localparam int HA = 16, HF = 2, HS = 3, HB = 3;
   localparam int VA = 12, VF = 1, VS = 2, VB = 2;
   localparam int R  = 2,  CW = 2, BF = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;

   logic          clk = 1'b0;
   logic          reset, pix_en, coord_valid, blink_en;
   logic [9:0]    xc, yc;
   logic [1:0]    mode;
   logic [3*CW-1:0] bg, cc;
   logic          vga_h_sync, vga_v_sync, frame_start;
   logic [CW-1:0] vga_r, vga_g, vga_b;

   vga_cursor_overlay #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .CURSOR_R(R), .COLOR_W(CW), .BLINK_FRAMES(BF)
   ) dut (
      .clk(clk), .reset(reset), .pix_en(pix_en),
      .x_coordinate(xc), .y_coordinate(yc), .coord_valid(coord_valid),
      .mode(mode), .blink_en(blink_en), .bg_color(bg), .cursor_color(cc),
      .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          hs;
      logic          vs;
      logic [3*CW-1:0] rgb;
   } exp_t;

   localparam exp_t RST_EXP = '{hs: 1'b1, vs: 1'b1, rgb: '0};

   exp_t q[$];
   int   n_vec = 0, n_err = 0;
   int   mh, mv, px, py, cx, cy, bcnt;
   bit   vis;

   // Screen-level reference: what colour/sync should appear for raster point (h,v).
   function automatic exp_t pixel(int h, int v);
      exp_t e;
      int dx, dy, ax, ay;
      bit hit, act, box;
      dx  = h - cx;
      dy  = v - cy;
      ax  = (dx < 0) ? -dx : dx;
      ay  = (dy < 0) ? -dy : dy;
      box = (ax <= R) && (ay <= R);
      case (mode)
         2'd1:    hit = box;
         2'd2:    hit = box && (ax == R || ay == R);
         2'd3:    hit = (dx == 0) || (dy == 0);
         default: hit = 1'b0;
      endcase
      act   = (h < HA) && (v < VA);
      e.hs  = !(h >= HA + HF && h < HA + HF + HS);
      e.vs  = !(v >= VA + VF && v < VA + VF + VS);
      e.rgb = !act ? '0 : ((hit && vis) ? cc : bg);
      return e;
   endfunction

   task automatic model_reset();
      mh = 0; mv = 0;
      px = HA / 2; py = VA / 2;
      cx = HA / 2; cy = VA / 2;
      bcnt = 0; vis = 1'b1;
      q.delete();
      q.push_back(RST_EXP);
   endtask

   // Reference model: advances on each clock edge and queues the expected output.
   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         if (reset) begin
            model_reset();
         end else begin
            int nx, ny;
            bit cv;
            cv = coord_valid;
            nx = (int'(xc) > HA - 1) ? HA - 1 : int'(xc);
            ny = (int'(yc) > VA - 1) ? VA - 1 : int'(yc);
            if (pix_en) begin
               q.push_back(pixel(mh, mv));
               if (mh == HT - 1 && mv == VA - 1) begin
                  cx = px; cy = py;
                  if (blink_en) begin
                     if (bcnt == BF - 1) begin bcnt = 0; vis = !vis; end
                     else bcnt++;
                  end
               end
               if (mh == HT - 1) begin
                  mh = 0;
                  mv = (mv == VT - 1) ? 0 : mv + 1;
               end else begin
                  mh++;
               end
            end
            if (!blink_en) begin bcnt = 0; vis = 1'b1; end
            if (cv) begin px = nx; py = ny; end
         end
      end
   end

   // Monitor: every pix_en edge the DUT presents one new output word.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!reset && pix_en) begin
            exp_t e, a;
            a = '{hs: vga_h_sync, vs: vga_v_sync, rgb: {vga_r, vga_g, vga_b}};
            n_vec++;
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL scoreboard_empty: got hs=%b vs=%b rgb=%h, want a queued entry",
                        a.hs, a.vs, a.rgb);
            end else begin
               e = q.pop_front();
               if (a !== e) begin
                  n_err++;
                  $display("FAIL pixel t=%0t: got hs=%b vs=%b rgb=%h, want hs=%b vs=%b rgb=%h",
                           $time, a.hs, a.vs, a.rgb, e.hs, e.vs, e.rgb);
               end
            end
         end
      end
   end

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, want %b", name, act, exp);
      end
   endtask

   task automatic drive(input bit pe, input bit cv, input int x, input int y);
      @(negedge clk);
      pix_en      = pe;
      coord_valid = cv;
      xc          = 10'(x);
      yc          = 10'(y);
      #1;
      check_bit("frame_start", frame_start, pe && !reset && mh == 0 && mv == 0);
   endtask

   task automatic run(input int cycles, input int pe_pct, input int cv_pct, input bit rnd_ctl);
      for (int i = 0; i < cycles; i++) begin
         if (rnd_ctl) begin
            if ($urandom_range(99) < 2) mode = 2'($urandom_range(3));
            if ($urandom_range(299) == 0) bg = 6'($urandom);
            if ($urandom_range(299) == 0) cc = 6'($urandom);
            if ($urandom_range(999) == 0) blink_en = !blink_en;
         end
         drive($urandom_range(99) < pe_pct, $urandom_range(99) < cv_pct,
               $urandom_range(1023), $urandom_range(1023));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_bit({tag, "_hsync"}, vga_h_sync, 1'b1);
      check_bit({tag, "_vsync"}, vga_v_sync, 1'b1);
      n_vec++;
      if ({vga_r, vga_g, vga_b} !== '0) begin
         n_err++;
         $display("FAIL %s_rgb: got %h, want 0", tag, {vga_r, vga_g, vga_b});
      end
      check_bit({tag, "_frame_start"}, frame_start, 1'b0);
   endtask

   localparam int FRAME = HT * VT;

   initial begin
      bit found;
      reset = 1'b1; pix_en = 1'b1; coord_valid = 1'b0;
      xc = '0; yc = '0; mode = 2'd1; blink_en = 1'b0;
      bg = 6'h3f; cc = 6'h00;
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      reset = 1'b0;

      // Steady timing, then a move requested mid-frame (must not tear).
      run(FRAME, 100, 0, 1'b0);
      repeat (7 * HT) drive(1, 0, 0, 0);
      drive(1, 1, 5, 3);
      run(2 * FRAME, 100, 0, 1'b0);

      // Corner cursor: visible quadrant only, for every shape.
      drive(1, 1, 0, 0);
      run(2 * FRAME, 100, 0, 1'b0);
      mode = 2'd2; run(FRAME, 100, 0, 1'b0);
      mode = 2'd3; run(FRAME, 100, 0, 1'b0);
      mode = 2'd0; run(FRAME / 2, 100, 0, 1'b0);

      // Clamp to bottom-right corner.
      mode = 2'd1;
      drive(1, 1, 1000, 900);
      run(2 * FRAME, 100, 0, 1'b0);
      drive(1, 1, 8, 6);
      mode = 2'd2; run(2 * FRAME, 100, 0, 1'b0);

      // Blink with continuous and half-rate pixel strobe.
      blink_en = 1'b1; mode = 2'd1; cc = 6'h15;
      run(5 * FRAME, 100, 0, 1'b0);
      for (int i = 0; i < 2 * FRAME; i++) drive(i[0], 0, 0, 0);

      // Random soak.
      run(10 * FRAME, 60, 2, 1'b1);

      // Asynchronous reset mid-line.
      blink_en = 1'b0; mode = 2'd3; bg = 6'h2a; cc = 6'h3f;
      found = 1'b0;
      for (int i = 0; i < 2 * FRAME && !found; i++) begin
         drive(1, 0, 0, 0);
         found = (mh == 10 && mv < VA);
      end
      n_vec++;
      if (!found) begin
         n_err++;
         $display("FAIL reset_window: got no mid-line point, want h=10 within bound");
      end
      #2 reset = 1'b1;
      #1 check_reset_outputs("async_reset");
      repeat (2) drive(1, 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;
      run(2 * FRAME, 100, 0, 1'b0);
      run(3 * FRAME, 70, 3, 1'b1);

      @(negedge clk);
      pix_en = 1'b0;
      n_vec++;
      if (q.size() != 1) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending, want 1", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vga_cursor_overlay.md
Name: vga_cursor_overlay

Overview:
- Parametrised successor to the single-box cursor display block.
- Integrates its own timing counters, a pixel-enable strobe, frame-synchronous (tear-free) cursor position update, edge-safe clamping, selectable cursor shape, blink, and multi-bit colour.
- Sits between the coordinate source (mouse/Bluetooth decoder) and the VGA DAC pins.
- Sync and colour outputs are pipeline-aligned.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CURSOR_R, 3, cursor half-size; the box spans 2*CURSOR_R+1 pixels per side
- COLOR_W, 1, bits per colour channel
- BLINK_FRAMES, 30, frames per blink half-period

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel strobe; all timing and pipeline state advances only when high
- x_coordinate  in  10  requested cursor X
- y_coordinate  in  10  requested cursor Y
- coord_valid  in  1  one-cycle qualifier that captures x/y into the pending registers
- mode  in  2  cursor shape: 0 off, 1 filled box, 2 outline box, 3 crosshair
- blink_en  in  1  enables cursor blink
- bg_color  in  3*COLOR_W  background colour {r,g,b}
- cursor_color  in  3*COLOR_W  cursor colour {r,g,b}
- vga_h_sync  out  1  horizontal sync, active-low
- vga_v_sync  out  1  vertical sync, active-low
- vga_r / vga_g / vga_b  out  COLOR_W each  pixel colour channels
- frame_start  out  1  one-clk pulse on the pix_en cycle where h_cnt=0 and v_cnt=0

Behaviour:
- Counters
  - h_cnt counts 0..H_TOTAL-1, where H_TOTAL = sum of the H_* parameters.
  - v_cnt counts 0..V_TOTAL-1 and increments when h_cnt wraps.
  - Both advance only on pix_en. With pix_en low, all outputs hold.
- Sync generation
  - Horizontal sync is low when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - Vertical sync uses the same rule with the V_* parameters.
  - Active area: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Coordinate capture
  - coord_valid=1 loads the clamped coordinates into pend_x/pend_y on that clk, regardless of pix_en.
  - X is clamped to H_ACTIVE-1 and Y to V_ACTIVE-1.
- Position commit (anti-tear)
  - cur_x/cur_y load from pend_x/pend_y on the pix_en cycle where h_cnt=H_TOTAL-1 and v_cnt=V_ACTIVE-1.
  - This is the last pixel before vertical blank, so the cursor never moves within a visible frame.
  - If coord_valid coincides with the commit cycle, the commit uses the old pend value; the new value commits next frame.
- Hit test
  - Uses 11-bit signed arithmetic: dx = h_cnt - cur_x, dy = v_cnt - cur_y.
  - No unsigned underflow at screen edges: a cursor at (0,0) draws only its visible quadrant, with no wrap to the far edge.
  - mode 1 hit: |dx| <= R and |dy| <= R.
  - mode 2 hit: mode 1 hit and (|dx| = R or |dy| = R).
  - mode 3 hit: dx = 0 or dy = 0, full-screen lines.
  - mode 0: never a hit.
- Blink
  - A frame counter increments at each commit point and wraps at BLINK_FRAMES-1.
  - The visible flag toggles on each wrap.
  - blink_en=0 forces visible=1 and holds the counter at 0.
- Pipeline (latency measured in pix_en cycles)
  - Stage 1 registers active, hit and the sync values.
  - Stage 2 registers the outputs:
    - colour = 0 when not active;
    - otherwise cursor_color if (hit and visible);
    - otherwise bg_color.
  - Syncs are delayed by the same 2 stages, so a colour and its sync always correspond to the same (h_cnt, v_cnt).
  - frame_start is undelayed.
- Reset (asynchronous)
  - h_cnt, v_cnt = 0.
  - pend and cur = (H_ACTIVE/2, V_ACTIVE/2).
  - Blink counter = 0, visible = 1.
  - Pipeline registers cleared.
  - vga_h_sync = vga_v_sync = 1.
  - Colours = 0, frame_start = 0.
- Reset asserted mid-frame: outputs return to the reset values immediately. After deassertion, timing restarts from (0,0).
- mode, blink_en and both colour inputs are sampled live in stage 1. Changes apply from the next pixel.

Test Plan:
- Timing: reset, then pix_en=1 continuously -> vga_h_sync low for exactly 96 pix_en cycles per 800-pixel line; vga_v_sync low for 2 lines of 800; frame_start period is 420000 cycles.
- Anti-tear: mode=1, coord_valid with (100,50) at v_cnt=200 -> current frame still draws at (320,240); next frame draws a black 7x7 box at x 97..103, y 47..53 when cursor_color=0 and bg_color=7.
- Edge safety: commit (0,0), mode=1 -> pixels x 0..3, y 0..3 are cursor colour; pixels at x=637..639 on rows 0..3 are background.
- Clamp and shapes: coord (1000,900) -> commits to (639,479). mode=2 at (320,240) -> (323,240) is cursor and (320,240) is background. mode=3 -> all of row 240 and column 320 are cursor.
- Blink and pix_en: blink_en=1, BLINK_FRAMES=2 -> cursor shown 2 frames, hidden 2 frames. pix_en toggling every other clk -> line period doubles in clk and colour stays aligned with sync at 2-pixel latency.
- Async reset mid-line at h_cnt=300 -> syncs go high and colours go 0 before the next clk edge; after release, cursor is at (320,240).
